operand_fetch: RTL

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/risc_pkg.sv | 32 +++
 rtl/regfile.sv | 40 ++++
 rtl/operand_fetch.sv | 136 +++++++++++++
 3 files changed

// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// risc_pkg : shared widths, FSM states and opcode/fcode encodings (fetch/ALU)
// Revision : 1.0
// ============================================================================
package risc_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int OPC_W  = 3;
  localparam int FC_W   = 5;

  localparam logic [OPC_W-1:0] OPC_ALU  = 3'b000;
  localparam logic [OPC_W-1:0] OPC_ALUI = 3'b001;
  localparam logic [OPC_W-1:0] OPC_LD   = 3'b010;
  localparam logic [OPC_W-1:0] OPC_ST   = 3'b011;
  localparam logic [OPC_W-1:0] OPC_BR   = 3'b100;

  localparam logic [FC_W-1:0] FC_ADD = 5'd0;
  localparam logic [FC_W-1:0] FC_SUB = 5'd1;
  localparam logic [FC_W-1:0] FC_AND = 5'd2;
  localparam logic [FC_W-1:0] FC_OR  = 5'd3;
  localparam logic [FC_W-1:0] FC_XOR = 5'd4;
  localparam logic [FC_W-1:0] FC_SLT = 5'd5;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } of_state_e;

endpackage : risc_pkg
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// regfile : NREG x DATA_W registers, 2 async read ports, 1 sync write port
// Revision : 1.0
// ============================================================================
module regfile
  import risc_pkg::*;
#(
  parameter int DATA_W = risc_pkg::DATA_W,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o
);

  logic [DATA_W-1:0] regs_q [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (32'(waddr_i) < NREG)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Reads return the pre-write contents; any same-cycle forwarding lives upstream.
  assign rdata1_o = (32'(raddr1_i) < NREG) ? regs_q[raddr1_i] : '0;
  assign rdata2_o = (32'(raddr2_i) < NREG) ? regs_q[raddr2_i] : '0;

endmodule : regfile
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// operand_fetch : one-entry skid stage reading operands for the ALU.
// Option macro  : OPERAND_FETCH_BYPASS_EN (writeback forwarding/refresh)
// Revision      : 1.0
// ============================================================================
module operand_fetch
  import risc_pkg::*;
#(
  parameter int DATA_W = risc_pkg::DATA_W,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [FC_W-1:0]   in_fcode,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_inp1,
  output logic [DATA_W-1:0] out_inp2,
  output logic [OPC_W-1:0]  out_opcode,
  output logic [FC_W-1:0]   out_fcode
);

  of_state_e         state_q, state_d;
  logic [DATA_W-1:0] inp1_q, inp1_d, inp2_q, inp2_d;
  logic [OPC_W-1:0]  opcode_q, opcode_d;
  logic [FC_W-1:0]   fcode_q, fcode_d;
  logic [DATA_W-1:0] rd1_w, rd2_w, op1_w, op2_w;
  logic              accept_w;
`ifdef OPERAND_FETCH_BYPASS_EN
  // Source tags of the held entry, needed to refresh it from writeback.
  logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d;
  logic              use_imm_q, use_imm_d;
`endif

  regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wb_en),
    .waddr_i  (wb_addr),
    .wdata_i  (wb_data),
    .raddr1_i (in_rs),
    .rdata1_o (rd1_w),
    .raddr2_i (in_rt),
    .rdata2_o (rd2_w)
  );

  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept_w  = in_valid && in_ready;

  always_comb begin
    op1_w = rd1_w;
    op2_w = rd2_w;
`ifdef OPERAND_FETCH_BYPASS_EN
    if (wb_en && (wb_addr == in_rs)) op1_w = wb_data;
    if (wb_en && (wb_addr == in_rt)) op2_w = wb_data;
`endif
    if (in_use_imm) op2_w = in_imm;
  end

  always_comb begin
    state_d  = state_q;
    inp1_d   = inp1_q;
    inp2_d   = inp2_q;
    opcode_d = opcode_q;
    fcode_d  = fcode_q;
`ifdef OPERAND_FETCH_BYPASS_EN
    rs_d      = rs_q;
    rt_d      = rt_q;
    use_imm_d = use_imm_q;
`endif
    case (state_q)
      ST_EMPTY: if (accept_w) state_d = ST_FULL;
      ST_FULL:  if (out_ready && !in_valid) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (accept_w) begin
      inp1_d   = op1_w;
      inp2_d   = op2_w;
      opcode_d = in_opcode;
      fcode_d  = in_fcode;
`ifdef OPERAND_FETCH_BYPASS_EN
      rs_d      = in_rs;
      rt_d      = in_rt;
      use_imm_d = in_use_imm;
    end else if (out_valid && !out_ready && wb_en) begin
      if (wb_addr == rs_q) inp1_d = wb_data;
      if ((wb_addr == rt_q) && !use_imm_q) inp2_d = wb_data;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      inp1_q   <= '0;
      inp2_q   <= '0;
      opcode_q <= '0;
      fcode_q  <= '0;
`ifdef OPERAND_FETCH_BYPASS_EN
      rs_q      <= '0;
      rt_q      <= '0;
      use_imm_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      inp1_q   <= inp1_d;
      inp2_q   <= inp2_d;
      opcode_q <= opcode_d;
      fcode_q  <= fcode_d;
`ifdef OPERAND_FETCH_BYPASS_EN
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      use_imm_q <= use_imm_d;
`endif
    end
  end

  assign out_inp1   = inp1_q;
  assign out_inp2   = inp2_q;
  assign out_opcode = opcode_q;
  assign out_fcode  = fcode_q;

endmodule : operand_fetch
`default_nettype wire
